delay_sample_prog: RTL and testbench
====================================

DELAY_SAMPLE_PROG -- requirements
Module: delay_sample_prog

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning sample width in bits.
REQ-002 SHALL have parameter MAX_DELAY, default 80, meaning the largest supported delay in samples; any integer 1..4095, not restricted to 2^n.
REQ-003 SHALL derive localparam ADDR_WIDTH = clog2(MAX_DELAY+1) for the storage depth.
REQ-004 SHALL have port clock  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  when low, strobes are ignored and state holds.
REQ-007 SHALL have port delay  input  ADDR_WIDTH  requested delay in samples, sampled only on delay_load.
REQ-008 SHALL have port delay_load  input  1  single-cycle pulse that latches delay and restarts fill.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  input sample.
REQ-010 SHALL have port input_strobe  input  1  data_in valid this cycle.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  delayed sample, registered.
REQ-012 SHALL have port output_strobe  output  1  data_out valid this cycle, single-cycle pulse.
REQ-013 SHALL have port primed  output  1  high once the delay line holds the latched delay's worth of samples.

Function
REQ-014 SHALL count delay in accepted strobes, not clock cycles; an accepted strobe is input_strobe=1 with enable=1.
REQ-015 SHALL, for latched delay D>=1 and the k-th accepted strobe since the last fill restart, once k>D, drive data_out equal to data_in of strobe k-D with output_strobe=1 exactly one cycle after strobe k.
REQ-016 SHALL hold output_strobe=0 one cycle after strobes with k<=D; primed rises in the cycle after the D-th accepted strobe.
REQ-017 SHALL, for D=0, register data_in to data_out with output_strobe=1 one cycle after every accepted strobe; primed=1 immediately.
REQ-018 SHALL clamp a delay value above MAX_DELAY to MAX_DELAY when latched.
REQ-019 SHALL implement storage as a circular buffer of MAX_DELAY+1 entries with write pointer wrapping from MAX_DELAY to 0; read index = write index - D modulo MAX_DELAY+1.
REQ-020 SHALL saturate the fill counter at D; no counter wrap after long runs.
REQ-021 SHALL, on delay_load, latch the clamped delay, clear fill count and primed, and suppress output_strobe for that cycle; buffer contents need not be cleared.
REQ-022 SHALL, when delay_load and an accepted strobe coincide, apply the new delay first and treat that strobe as k=1 under the new delay.
REQ-023 SHALL, when enable=0, drive output_strobe=0 next cycle, hold data_out, pointers, fill count and primed; delay_load is still honoured.
REQ-024 SHALL hold data_out unchanged between output strobes.
REQ-025 SHALL accept back-to-back strobes every cycle with no throughput loss.

Reset
REQ-026 SHALL, on reset, set data_out=0, output_strobe=0, primed=0, write pointer=0, fill count=0, latched delay=MAX_DELAY.
REQ-027 SHALL give reset priority over delay_load, enable and input_strobe; a reset mid-stream discards all prior samples and restarts fill.

Verification
REQ-028 SHALL verify: MAX_DELAY=80, load D=16, 40 back-to-back strobes data_in=1..40 -> output_strobe on strobes 17..40, data_out=1..24, primed high after strobe 16.
REQ-029 SHALL verify: load D=80 (non-2^n) with strobe every 3rd cycle, 200 samples -> each data_out equals input 80 strobes earlier; pointer wraps twice with no glitch.
REQ-030 SHALL verify: load D=0, strobes data_in=5,6,7 -> data_out=5,6,7 each one cycle after its strobe, output_strobe every strobe.
REQ-031 SHALL verify: load D=100 with MAX_DELAY=80 -> behaves as D=80; then after 90 strobes reload D=4 coincident with a strobe of value X -> no output until 4 further strobes, then data_out=X.
REQ-032 SHALL verify: enable low for 10 cycles with strobes toggling mid-fill at D=8 -> no output_strobe, fill resumes from prior count when enable returns.
REQ-033 SHALL verify: reset asserted after 50 strobes at D=16 -> next cycle data_out=0, primed=0, latched delay=80; outputs resume only after 80 new strobes.

Source files
------------

// File: rtl/delay_sample_prog.sv
// delay_sample_prog: programmable sample delay line.
// Delays accepted input samples by a run-time programmable number of strobes.
// Storage is a circular buffer of MAX_DELAY+1 entries.
// Ports:
//   clock         - single clock, rising edge
//   reset         - synchronous active-high reset
//   enable        - gates input strobes; state holds while low
//   delay         - requested delay in samples, latched on delay_load
//   delay_load    - pulse: latch clamped delay and restart fill
//   data_in       - input sample
//   input_strobe  - data_in valid
//   data_out      - delayed sample (registered, held between strobes)
//   output_strobe - data_out valid pulse
//   primed        - delay line holds the latched delay's worth of samples
module delay_sample_prog #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_DELAY  = 80,
    localparam int unsigned ADDR_WIDTH = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic                  delay_load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  input_strobe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_strobe,
    output logic                  primed
);

    localparam int unsigned DEPTH = MAX_DELAY + 1;
    localparam int unsigned SUM_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_D = ADDR_WIDTH'(MAX_DELAY);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_delay;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_fill;
    logic                  r_primed;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_out_strobe;

    logic [ADDR_WIDTH-1:0] w_delay_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_fill_nxt;
    logic                  w_primed_nxt;
    logic [DATA_WIDTH-1:0] w_data_out_nxt;
    logic                  w_out_strobe_nxt;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_delay_clamp;
    logic [ADDR_WIDTH-1:0] w_delay_eff;
    logic [ADDR_WIDTH-1:0] w_fill_eff;
    logic [SUM_W-1:0]      w_rd_sum;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    assign w_accept      = enable & input_strobe;
    assign w_delay_clamp = (delay > MAX_D) ? MAX_D : delay;

    // A load in the same cycle as a strobe applies the new delay to that strobe.
    assign w_delay_eff = delay_load ? w_delay_clamp : r_delay;
    assign w_fill_eff  = delay_load ? '0 : r_fill;

    // Read index = write index - delay, modulo DEPTH (DEPTH need not be 2^n).
    always_comb begin
        w_rd_sum = '0;
        if (r_wr_ptr >= w_delay_eff) begin
            w_rd_sum = {1'b0, r_wr_ptr} - {1'b0, w_delay_eff};
        end else begin
            w_rd_sum = {1'b0, r_wr_ptr} + SUM_W'(DEPTH) - {1'b0, w_delay_eff};
        end
    end

    assign w_rd_idx = w_rd_sum[ADDR_WIDTH-1:0];

    // Next-state for control, fill tracking and output register.
    always_comb begin
        w_delay_nxt      = r_delay;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_fill_nxt       = r_fill;
        w_primed_nxt     = r_primed;
        w_data_out_nxt   = r_data_out;
        w_out_strobe_nxt = 1'b0;

        if (delay_load) begin
            w_delay_nxt  = w_delay_clamp;
            w_fill_nxt   = '0;
            w_primed_nxt = (w_delay_clamp == '0);
        end

        if (w_accept) begin
            w_wr_ptr_nxt = (r_wr_ptr == MAX_D) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);

            // Fill saturated at the delay means this strobe is k > D.
            if (w_fill_eff == w_delay_eff) begin
                w_out_strobe_nxt = 1'b1;
                // Zero delay reads the slot being written this cycle: bypass it.
                w_data_out_nxt   = (w_delay_eff == '0) ? data_in : r_mem[w_rd_idx];
                w_primed_nxt     = 1'b1;
            end else begin
                w_fill_nxt = w_fill_eff + ADDR_WIDTH'(1);
                if ((w_fill_eff + ADDR_WIDTH'(1)) == w_delay_eff) begin
                    w_primed_nxt = 1'b1;
                end
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_delay      <= MAX_D;
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_primed     <= 1'b0;
            r_data_out   <= '0;
            r_out_strobe <= 1'b0;
        end else begin
            r_delay      <= w_delay_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_fill       <= w_fill_nxt;
            r_primed     <= w_primed_nxt;
            r_data_out   <= w_data_out_nxt;
            r_out_strobe <= w_out_strobe_nxt;
        end
    end

    // Sample storage; contents are never cleared, fill tracking guards reads.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign data_out      = r_data_out;
    assign output_strobe = r_out_strobe;
    assign primed        = r_primed;

endmodule

// File: tb/tb_delay_sample_prog.sv
// tb_delay_sample_prog: randomized self-checking bench for delay_sample_prog.
// Reference model: queue of accepted samples since the last restart plus a
// strobe count k; output is the sample D entries back once k exceeds D.
module tb_delay_sample_prog;

    localparam int unsigned DW   = 32;
    localparam int unsigned MAXD = 80;
    localparam int unsigned AW   = $clog2(MAXD + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] delay = '0;
    logic          delay_load = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          input_strobe = 1'b0;
    logic [DW-1:0] data_out;
    logic          output_strobe;
    logic          primed;

    delay_sample_prog #(.DATA_WIDTH(DW), .MAX_DELAY(MAXD)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .delay         (delay),
        .delay_load    (delay_load),
        .data_in       (data_in),
        .input_strobe  (input_strobe),
        .data_out      (data_out),
        .output_strobe (output_strobe),
        .primed        (primed)
    );

    always #5 clock = ~clock;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned out_cnt = 0;

    int          m_d = MAXD;
    int          m_k = 0;
    logic [DW-1:0] m_out = '0;
    bit          m_ostb = 0;
    bit          m_primed = 0;
    logic [DW-1:0] hist [$];

    // One clock: apply inputs, advance the model at the edge, compare after it.
    task automatic cyc(input bit rst, input bit ld, input int unsigned dv,
                       input bit en, input bit st, input logic [DW-1:0] din);
        reset        = rst;
        delay_load   = ld;
        delay        = AW'(dv);
        enable       = en;
        input_strobe = st;
        data_in      = din;
        @(posedge clock);
        if (rst) begin
            m_out = '0; m_ostb = 0; m_primed = 0; m_d = MAXD; m_k = 0;
            hist.delete();
        end else begin
            m_ostb = 0;
            if (ld) begin
                m_d = (dv > MAXD) ? MAXD : int'(dv);
                m_k = 0;
                m_primed = (m_d == 0);
                hist.delete();
            end
            if (en && st) begin
                hist.push_back(din);
                m_k++;
                if (m_k > m_d) begin
                    m_out  = hist[hist.size() - 1 - m_d];
                    m_ostb = 1;
                end
                if (m_k >= m_d) m_primed = 1;
                if (hist.size() > MAXD + 1) void'(hist.pop_front());
            end
        end
        #1;
        if (output_strobe) out_cnt++;
        vectors++;
        if (output_strobe !== m_ostb) begin
            miscompares++;
            $display("FAIL output_strobe t=%0t got %0b exp %0b", $time, output_strobe, m_ostb);
        end
        vectors++;
        if (data_out !== m_out) begin
            miscompares++;
            $display("FAIL data_out t=%0t got %0h exp %0h", $time, data_out, m_out);
        end
        vectors++;
        if (primed !== m_primed) begin
            miscompares++;
            $display("FAIL primed t=%0t got %0b exp %0b", $time, primed, m_primed);
        end
        reset = 0; delay_load = 0; input_strobe = 0;
    endtask

    task automatic strobe(input logic [DW-1:0] din);
        cyc(0, 0, 0, 1, 1, din);
    endtask

    task automatic load(input int unsigned dv);
        cyc(0, 1, dv, 1, 0, '0);
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 1, 3, 1, 1, 32'hdead);
        vectors++;
        if (data_out !== '0 || output_strobe !== 1'b0 || primed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got out=%0h os=%0b pr=%0b exp 0/0/0",
                     data_out, output_strobe, primed);
        end
    endtask

    task automatic test_d16;
        logic [DW-1:0] first;
        first = '0;
        load(16);
        out_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            strobe(DW'(i));
            if (i == 17) first = data_out;
        end
        vectors++;
        if (out_cnt != 24) begin
            miscompares++;
            $display("FAIL d16_count got %0d exp 24", out_cnt);
        end
        vectors++;
        if (first !== DW'(1)) begin
            miscompares++;
            $display("FAIL d16_first got %0h exp 1", first);
        end
        vectors++;
        if (data_out !== DW'(24)) begin
            miscompares++;
            $display("FAIL d16_last got %0h exp 24", data_out);
        end
    endtask

    task automatic test_d80_sparse;
        load(80);
        out_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            strobe($urandom);
            cyc(0, 0, 0, 1, 0, $urandom);
            cyc(0, 0, 0, 1, 0, $urandom);
        end
        vectors++;
        if (out_cnt != 120) begin
            miscompares++;
            $display("FAIL d80_count got %0d exp 120", out_cnt);
        end
    endtask

    task automatic test_d0;
        load(0);
        out_cnt = 0;
        for (int i = 5; i <= 7; i++) begin
            strobe(DW'(i));
            vectors++;
            if (data_out !== DW'(i) || output_strobe !== 1'b1) begin
                miscompares++;
                $display("FAIL d0_pass got %0h/%0b exp %0h/1", data_out, output_strobe, i);
            end
            cyc(0, 0, 0, 1, 0, '0);
        end
        vectors++;
        if (out_cnt != 3) begin
            miscompares++;
            $display("FAIL d0_count got %0d exp 3", out_cnt);
        end
    endtask

    task automatic test_clamp_reload;
        logic [DW-1:0] x;
        load(100);
        out_cnt = 0;
        for (int i = 1; i <= 90; i++) strobe(DW'(i));
        vectors++;
        if (out_cnt != 10 || data_out !== DW'(10)) begin
            miscompares++;
            $display("FAIL clamp got cnt=%0d out=%0h exp 10/a", out_cnt, data_out);
        end
        x = $urandom;
        cyc(0, 1, 4, 1, 1, x);
        out_cnt = 0;
        for (int i = 0; i < 3; i++) strobe($urandom);
        vectors++;
        if (out_cnt != 0) begin
            miscompares++;
            $display("FAIL reload_quiet got %0d exp 0", out_cnt);
        end
        strobe($urandom);
        vectors++;
        if (output_strobe !== 1'b1 || data_out !== x) begin
            miscompares++;
            $display("FAIL reload_x got %0h/%0b exp %0h/1", data_out, output_strobe, x);
        end
    endtask

    task automatic test_enable;
        load(8);
        for (int i = 0; i < 4; i++) strobe($urandom);
        out_cnt = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, i[0], $urandom);
        vectors++;
        if (out_cnt != 0 || primed !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_hold got cnt=%0d pr=%0b exp 0/0", out_cnt, primed);
        end
        for (int i = 0; i < 4; i++) strobe($urandom);
        vectors++;
        if (out_cnt != 0 || primed !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_resume got cnt=%0d pr=%0b exp 0/1", out_cnt, primed);
        end
        strobe($urandom);
        vectors++;
        if (output_strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_first got %0b exp 1", output_strobe);
        end
    endtask

    task automatic test_reset_midstream;
        load(16);
        for (int i = 0; i < 50; i++) strobe($urandom);
        cyc(1, 0, 0, 1, 1, $urandom);
        vectors++;
        if (data_out !== '0 || primed !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset got %0h/%0b exp 0/0", data_out, primed);
        end
        out_cnt = 0;
        for (int i = 0; i < 80; i++) strobe($urandom);
        vectors++;
        if (out_cnt != 0 || primed !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_fill got cnt=%0d pr=%0b exp 0/1", out_cnt, primed);
        end
        strobe($urandom);
        vectors++;
        if (output_strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_resume got %0b exp 1", output_strobe);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 59) == 0),
                $urandom_range(0, 127),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 9) < 6),
                $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_d16();
        test_d80_sparse();
        test_d0();
        test_clamp_reload();
        test_enable();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
